ula_sequenciador: RTL and testbench
===================================

Name: ula_sequenciador

Overview:
- Multicycle control unit that sequences the team's 16-bit ALU: fetches an instruction word from `din`, reads an internal 8-entry register file, drives the ALU control/operand ports, captures the ALU result and writes it back.
- Sits between the instruction/data source and the ALU instance.
- The ALU is external; this block owns the registers, the result latch G and the run/done handshake.

Parameters:
- WIDTH, 16, datapath width of registers, operands, immediate and ALU result. The instruction format below is fixed for WIDTH=16.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- run  input  1  start request, sampled only in IDLE
- din  input  WIDTH  instruction word (IDLE), immediate word (IMM)
- done  output  1  high for exactly the WB cycle of each instruction
- busy  output  1  high in every state except IDLE
- alu_ctrl  output  3  ALU operation select
- alu_a  output  WIDTH  ALU operand A
- alu_b  output  WIDTH  ALU operand B
- alu_g  output  WIDTH  ALU G operand (MVNZ condition)
- alu_result  input  WIDTH  ALU combinational result
- dbg_sel  input  3  register index for debug readout
- dbg_data  output  WIDTH  combinational R[dbg_sel]
- flag_z  output  1  zero flag (see Optional Feature)

Behaviour:
- Instruction format, 16 bits:
  - [15:13] op, passed to alu_ctrl: 0 ADD, 1 SUB, 2 AND, 3 SLL, 4 SRL, 5 SLT, 6 MVNZ, 7 MV.
  - [12] imm.
  - [11:9] X, destination and operand A register.
  - [8:6] Y, operand B register.
  - [5:0] ignored.
- State register values:
  - Internal: IR, IMM, G, R0..R7.
  - Reset: all of them 0; state IDLE.
- Outputs at reset: done=0, busy=0, flag_z=0, alu_* = 0.
- IDLE:
  - busy=0.
  - run=1 at the edge: IR<=din, then go to IMM if din[12]=1, else EXEC.
  - run=0: stay in IDLE.
- IMM: IMM<=din at the edge; go to EXEC. No run or valid qualifier on din; the source must present the immediate in this cycle.
- EXEC:
  - alu_ctrl=IR[15:13], alu_a=R[X].
  - alu_b = IMM if IR[12] else R[Y].
  - alu_g = G, the result of the previous instruction.
  - At the edge: G<=alu_result; go to WB.
- WB: done=1; at the edge R[X]<=G; go to IDLE.
- alu_ctrl/alu_a/alu_b/alu_g:
  - Combinational, driven only in EXEC.
  - 0 in all other states.
- Latency from the edge that samples run: done is high in the 2nd following cycle (no immediate) or the 3rd (immediate). Register visible on dbg_data the cycle after done.
- Back-to-back: run may be held high; the next instruction is sampled in the cycle after WB, in IDLE.
- run in a non-IDLE state: ignored, never queued.
- Arithmetic: no widening or saturation; the ALU result is truncated to WIDTH, so SUB wraps (3-8 = 0xFFFB).
- MVNZ: the ALU selects A when G==0, so R[X] is left unchanged (rewritten with its own value).
- X==Y: legal; both operands read the same register.
- Read/write timing: the read in EXEC sees the value before this instruction's write; there is no forwarding and none is needed.
- Reset asserted mid-instruction: immediate return to IDLE, all registers and G cleared, done/busy drop asynchronously, the instruction is discarded.

Optional Feature:
- ULA_SEQ_FLAGS_EN defined:
  - flag_z is a register, updated at the WB edge to (G==0).
  - Reset value 0; held between instructions.
- Undefined: flag_z is tied to 0 and no flag register exists.

Test Plan:
- MVI R1,5: reset, then din=0xF200 with run=1 for 1 cycle, then din=0x0005 -> busy 3 cycles, done in the 3rd cycle after run, dbg_sel=1 gives 0x0005.
- MVI R2,3 then ADD R1,R2 (0x0280) -> in EXEC alu_ctrl=0, alu_a=5, alu_b=3; R1=8; done in the 2nd cycle after run.
- SUB R2,R1 (0x2440) with R2=3, R1=8 -> R2=0xFFFB (wrap); back-to-back with run held high completes both instructions with no lost cycle beyond IDLE.
- MVNZ sequencing:
  - SUB R3,R3 (0x26C0) gives G=0.
  - MVNZ R4,R1 (0xC840) -> alu_g=0, R4 stays 0.
  - After ADD R1,R2 makes G≠0, MVNZ R4,R1 -> R4 = R1.
- Pulse run during EXEC of an instruction -> no extra instruction executes; then assert reset during EXEC -> busy=0, done=0, all R=0, state IDLE immediately.
- Flags:
  - With ULA_SEQ_FLAGS_EN, SUB R3,R3 -> flag_z=1 after WB; ADD giving 8 -> flag_z=0.
  - Without the macro, flag_z stays 0 throughout.

Source files
------------

// File: rtl/ula_sequenciador_if.sv
// Instruction-side bus between the instruction/data source and the ALU sequencer.
// run is a level request sampled only in IDLE; din carries the instruction word there and the immediate in IMM; done strobes for the single WB cycle; busy is high outside IDLE.
interface ula_sequenciador_if #(
  parameter int WIDTH = 16
);
  logic             run;
  logic [WIDTH-1:0] din;
  logic             done;
  logic             busy;

  modport master (output run, output din, input done, input busy);
  modport slave  (input run, input din, output done, output busy);
endinterface

// File: rtl/ula_sequenciador.sv
// Multicycle control unit driving an external 16-bit ALU: fetch, optional immediate, execute, write back.
// Optional zero flag register enabled by defining ULA_SEQ_FLAGS_EN; otherwise flag_z is tied low.
module ula_sequenciador #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  ula_sequenciador_if.slave bus,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_g,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic             flag_z,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMM  = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] r [8];
  logic [2:0]       rx;
  logic [2:0]       ry;

  assign rx = ir[11:9];
  assign ry = ir[8:6];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
      imm   <= '0;
      g     <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.run) ir <= bus.din;
        IMM:  imm <= bus.din;
        EXEC: g <= alu_result;
        WB:   r[rx] <= g;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    bus.done  = 1'b0;
    bus.busy  = 1'b1;
    alu_ctrl  = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_g     = '0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.run) state_nxt = bus.din[12] ? IMM : EXEC;
      end
      IMM: state_nxt = EXEC;
      EXEC: begin
        // Operands come from the register file before this instruction's write-back.
        alu_ctrl  = ir[15:13];
        alu_a     = r[rx];
        alu_b     = ir[12] ? imm : r[ry];
        alu_g     = g;
        state_nxt = WB;
      end
      WB: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ULA_SEQ_FLAGS_EN
  logic flag_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) flag_q <= 1'b0;
    else if (state == WB) flag_q <= (g == '0);
  end

  assign flag_z = flag_q;
`else
  assign flag_z = 1'b0;
`endif

  assign dbg_data  = r[dbg_sel];
  assign dbg_state = state;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador: behavioural ALU, instruction-level register model, scoreboard queue and monitor.
module tb_ula_sequenciador;
  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_g, alu_result;
  logic [2:0]   dbg_sel;
  logic [W-1:0] dbg_data;
  logic         flag_z;
  logic [1:0]   dbg_state;

  ula_sequenciador_if #(.WIDTH(W)) bus ();

  ula_sequenciador #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_g      (alu_g),
    .alu_result (alu_result),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .flag_z     (flag_z),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- external ALU and reference model ----------------
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] gv);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a << b[3:0];
      3'd4: return a >> b[3:0];
      3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd6: return (gv != 0) ? b : a;
      default: return b;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b, alu_g);

  typedef struct packed {
    logic [2:0]   x;
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic [W-1:0] res;
    logic         flag;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] rm [8];
  logic [W-1:0] gm;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rm[i] = '0;
    gm = '0;
  endtask

  task automatic model_issue(input logic [W-1:0] ins, input logic [W-1:0] immv);
    exp_t e;
    e.x    = ins[11:9];
    e.ctrl = ins[15:13];
    e.a    = rm[ins[11:9]];
    e.b    = ins[12] ? immv : rm[ins[8:6]];
    e.g    = gm;
    e.res  = alu_fn(e.ctrl, e.a, e.b, e.g);
    e.flag = (e.res == 0);
    exp_q.push_back(e);
    gm         = e.res;
    rm[e.x]    = e.res;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  exp_t pe;
  bit   pend = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("dbg_data_after_wb", 64'(dbg_data), 64'(pe.res));
`ifdef ULA_SEQ_FLAGS_EN
          chk("flag_z", 64'(flag_z), 64'(pe.flag));
`else
          chk("flag_z_tied", 64'(flag_z), 64'd0);
`endif
          pend = 0;
        end
        if (dbg_state == 2'd2) begin
          if (exp_q.size() == 0) note_fail("exec_without_expected_instruction");
          else begin
            chk("alu_ctrl", 64'(alu_ctrl), 64'(exp_q[0].ctrl));
            chk("alu_a", 64'(alu_a), 64'(exp_q[0].a));
            chk("alu_b", 64'(alu_b), 64'(exp_q[0].b));
            chk("alu_g", 64'(alu_g), 64'(exp_q[0].g));
          end
        end else begin
          chk("alu_outputs_idle", 64'({alu_ctrl, alu_a, alu_b, alu_g}), 64'd0);
        end
        if (bus.done) begin
          if (exp_q.size() == 0) note_fail("done_without_expected_instruction");
          else begin
            pe      = exp_q.pop_front();
            dbg_sel = pe.x;
            pend    = 1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_instr(input logic [W-1:0] ins, input logic [W-1:0] immv,
                           input bit hold, input bit pulse_exec);
    int exec_n;
    int n;
    bit seen;
    exec_n = ins[12] ? 2 : 1;
    @(negedge clock);
    bus.run = 1'b1;
    bus.din = ins;
    model_issue(ins, immv);
    @(posedge clock);
    n    = 0;
    seen = 0;
    while (!seen && n < 8) begin
      @(negedge clock);
      n++;
      if (n == 1 && ins[12]) bus.din = immv;
      if (!hold) bus.run = (pulse_exec && n == exec_n);
      chk("busy_during_instr", 64'(bus.busy), 64'd1);
      if (bus.done) begin
        seen = 1;
        chk("done_latency", 64'(n), 64'(exec_n + 1));
      end
    end
    if (!seen) note_fail("done_timeout");
  endtask

  initial begin
    logic [W-1:0] ins;
    logic [W-1:0] immv;
    reset   = 1'b1;
    bus.run = 1'b0;
    bus.din = '0;
    dbg_sel = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_flag_z", 64'(flag_z), 64'd0);
    chk("reset_alu", 64'({alu_ctrl, alu_a, alu_b, alu_g}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 chk("reset_reg", 64'(dbg_data), 64'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Directed sequence
    run_instr(16'hF200, 16'h0005, 0, 0);   // MVI R1,5
    run_instr(16'hF400, 16'h0003, 0, 0);   // MVI R2,3
    run_instr(16'h0280, 16'h0000, 0, 0);   // ADD R1,R2 -> 8
    run_instr(16'h2440, 16'h0000, 1, 0);   // SUB R2,R1 -> FFFB, run held
    run_instr(16'h26C0, 16'h0000, 1, 0);   // SUB R3,R3 -> G=0
    run_instr(16'hC840, 16'h0000, 0, 0);   // MVNZ R4,R1 with G=0 -> R4 stays 0
    run_instr(16'h0280, 16'h0000, 0, 0);   // ADD R1,R2 -> 3, G!=0
    run_instr(16'hC840, 16'h0000, 0, 0);   // MVNZ R4,R1 -> R4=R1

    // run pulsed during EXEC must not start another instruction
    run_instr(16'h0280, 16'h0000, 0, 1);
    @(negedge clock);
    bus.run = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("no_extra_instr_busy", 64'(bus.busy), 64'd0);
    end

    // Reset asserted during EXEC discards the instruction
    @(negedge clock);
    bus.run = 1'b1;
    bus.din = 16'h0280;
    model_issue(16'h0280, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    bus.run = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    chk("midreset_state", 64'(dbg_state), 64'd0);
    chk("midreset_flag_z", 64'(flag_z), 64'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 chk("midreset_reg", 64'(dbg_data), 64'd0);
    end
    exp_q.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Randomized instructions, with and without immediates and back-to-back runs
    for (int k = 0; k < 60; k++) begin
      ins  = 16'($urandom_range(0, 65535));
      immv = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) ins[15:13] = 3'd1;
      if ($urandom_range(0, 5) == 0) ins[8:6] = ins[11:9];
      run_instr(ins, immv, (k != 59) && ($urandom_range(0, 1) == 1), 0);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clock);
        bus.run = 1'b0;
      end
    end
    @(negedge clock);
    bus.run = 1'b0;
    repeat (4) @(negedge clock);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 chk("final_reg", 64'(dbg_data), 64'(rm[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
